// File: rtl/fpu_result_collector.sv
// fpu_result_collector: aligns FPU results with issue tags and queues them in a show-ahead FIFO
// with sticky exception flags and an overflow indicator.
module fpu_result_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [2:0]               issue_op,
  input  logic [31:0]              out,
  input  logic [7:0]               fpu_flags,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [2:0]               res_op,
  output logic [7:0]               res_flags,
  output logic [7:0]               sticky_flags,
  input  logic                     sticky_clr,
  output logic                     lost,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [LATENCY-1:0] tag_v_q, tag_v_d;
  logic [2:0]         tag_op_q [LATENCY];
  logic [2:0]         tag_op_d [LATENCY];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [7:0]         sticky_q, sticky_d;
  logic               lost_q, lost_d;
  logic [42:0]        mem [DEPTH];
  logic [42:0]        head;
  logic               cap, pop, full, push, drop;
  always_comb begin
    tag_v_d[0]  = issue_valid;
    tag_op_d[0] = issue_op;
    for (int i = 1; i < LATENCY; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_op_d[i] = tag_op_q[i-1];
    end
    cap      = tag_v_q[LATENCY-1];
    pop      = res_valid & res_ready;
    full     = count_q == CW'(DEPTH);
    // a full FIFO still accepts a capture when the head leaves in the same cycle
    push     = cap & (!full | pop);
    drop     = cap & full & !pop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = (push & !pop) ? count_q + CW'(1) : (pop & !push) ? count_q - CW'(1) : count_q;
    sticky_d = (sticky_clr ? 8'h00 : sticky_q) | (cap ? fpu_flags : 8'h00);
    lost_d   = (!sticky_clr & lost_q) | drop;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q  <= '0;
      for (int i = 0; i < LATENCY; i++) tag_op_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      tag_v_q  <= tag_v_d;
      for (int i = 0; i < LATENCY; i++) tag_op_q[i] <= tag_op_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      lost_q   <= lost_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {out, tag_op_q[LATENCY-1], fpu_flags};
  end
  assign res_valid    = count_q != '0;
  assign head         = res_valid ? mem[rd_ptr_q] : '0;
  assign res_data     = head[42:11];
  assign res_op       = head[10:8];
  assign res_flags    = head[7:0];
  assign sticky_flags = sticky_q;
  assign lost         = lost_q;
  assign count        = count_q;
endmodule

// File: tb/tb_fpu_result_collector.sv
// tb_fpu_result_collector: directed vector table plus hand sequences for overflow, full+pop and reset.
module tb_fpu_result_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_op;
  logic [31:0] out;
  logic [7:0]  fpu_flags;
  logic        res_valid, res_ready, sticky_clr, lost;
  logic [31:0] res_data;
  logic [2:0]  res_op;
  logic [7:0]  res_flags, sticky_flags;
  logic [2:0]  count;
  int          nvec = 0;
  int          nerr = 0;
  localparam int L = 4;
  typedef struct {
    logic iv; logic [2:0] op; logic [31:0] o; logic [7:0] fl; logic rdy; logic clr;
    logic ev; logic [31:0] ed; logic [2:0] eo; logic [7:0] ef; logic [2:0] ec; logic [7:0] es; logic el;
  } vec_t;
  vec_t tbl [17];

  fpu_result_collector dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op), .out(out),
    .fpu_flags(fpu_flags), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_flags(res_flags), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .lost(lost), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic iv, input logic [2:0] op, input logic [31:0] o,
                      input logic [7:0] fl, input logic rdy, input logic clr);
    issue_valid = iv; issue_op = op; out = o; fpu_flags = fl; res_ready = rdy; sticky_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic seen;
    tbl[0]  = '{1, 3'd3, 32'h0,        8'h00, 0, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h00, 0};
    tbl[1]  = '{1, 3'd5, 32'h0,        8'h00, 0, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h00, 0};
    tbl[2]  = '{0, 3'd0, 32'h0,        8'h00, 0, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h00, 0};
    tbl[3]  = '{0, 3'd0, 32'h0,        8'h00, 0, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h00, 0};
    tbl[4]  = '{0, 3'd0, 32'h3F800000, 8'h03, 0, 0, 1, 32'h3F800000, 3'd3, 8'h03, 3'd1, 8'h03, 0};
    tbl[5]  = '{0, 3'd0, 32'h40000000, 8'h08, 1, 0, 1, 32'h40000000, 3'd5, 8'h08, 3'd1, 8'h0B, 0};
    tbl[6]  = '{0, 3'd0, 32'h0,        8'h00, 1, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h0B, 0};
    tbl[7]  = '{0, 3'd7, 32'hFFFFFFFF, 8'hFF, 0, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h0B, 0};
    tbl[8]  = '{0, 3'd0, 32'hDEADBEEF, 8'hC0, 0, 1, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h00, 0};
    tbl[9]  = '{1, 3'd1, 32'h0,        8'h00, 0, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h00, 0};
    tbl[10] = '{1, 3'd2, 32'h0,        8'h00, 0, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h00, 0};
    tbl[11] = '{0, 3'd0, 32'h0,        8'h00, 0, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h00, 0};
    tbl[12] = '{0, 3'd0, 32'h0,        8'h00, 0, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h00, 0};
    tbl[13] = '{0, 3'd0, 32'h0000AAAA, 8'h04, 0, 0, 1, 32'h0000AAAA, 3'd1, 8'h04, 3'd1, 8'h04, 0};
    tbl[14] = '{0, 3'd0, 32'h0000BBBB, 8'h10, 0, 1, 1, 32'h0000AAAA, 3'd1, 8'h04, 3'd2, 8'h10, 0};
    tbl[15] = '{0, 3'd0, 32'h0,        8'h00, 1, 0, 1, 32'h0000BBBB, 3'd2, 8'h10, 3'd1, 8'h10, 0};
    tbl[16] = '{0, 3'd0, 32'h0,        8'h00, 1, 0, 0, 32'h0,        3'd0, 8'h00, 3'd0, 8'h10, 0};

    issue_valid = 0; issue_op = 0; out = 0; fpu_flags = 0; res_ready = 0; sticky_clr = 0;
    do_reset();
    chk("reset_state", {res_valid, res_data, res_op, res_flags, count, sticky_flags, lost}, 56'h0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].iv, tbl[i].op, tbl[i].o, tbl[i].fl, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("row%0d", i),
          {res_valid, res_data, res_op, res_flags, count, sticky_flags, lost},
          {tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].ef, tbl[i].ec, tbl[i].es, tbl[i].el});
    end

    // overflow: five results into a four-entry FIFO, fifth is dropped
    do_reset();
    for (int k = 0; k < 9; k++) step(k < 5, 3'(k), k >= 4 ? 32'(k - 3) : 32'h0, 8'h00, 0, 0);
    chk("ovf_count", count, 4);
    chk("ovf_lost", lost, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_pop%0d", i), res_data, i);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("ovf_empty", {res_valid, count, res_data}, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("ovf_lost_clr", lost, 0);

    // full FIFO with a capture coinciding with a pop
    for (int k = 0; k < 9; k++) step(k < 5, 3'(k), k >= 4 ? 32'(10 + k - 4) : 32'h0, 8'h00, k == 8, 0);
    chk("fullpop_count", count, 4);
    chk("fullpop_lost", lost, 0);
    for (int i = 11; i <= 14; i++) begin
      chk($sformatf("fullpop_pop%0d", i), res_data, i);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("fullpop_empty", count, 0);

    // reset with two entries queued and two tags in flight
    for (int k = 0; k < 8; k++) step(k == 0 || k == 1 || k == 4 || k == 5, 3'd6,
                                     (k == 4 || k == 5) ? 32'h55 : 32'h0, 8'h01, 0, 0);
    chk("mid_count", count, 2);
    #2 rst = 1'b1;
    #1 chk("async_rst", {res_valid, res_data, res_op, res_flags, count, sticky_flags, lost}, 56'h0);
    #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 2 * L; k++) begin
      step(0, 0, 32'h77, 8'hFF, 0, 0);
      seen |= res_valid;
    end
    chk("no_ghost_valid", {seen, sticky_flags}, 0);

    // idle noise on the result bus
    for (int k = 0; k < 10; k++) step(0, 3'(k), 32'h1234_0000 + 32'(k * 77), 8'(k * 37 + 1), 0, 0);
    chk("idle_noise", {count, sticky_flags, res_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fpu_result_collector.md
FPU_RESULT_COLLECTOR -- requirements
Module: fpu_result_collector

Interface
REQ-001 The module SHALL have parameter LATENCY, default 4, giving FPU issue-to-result latency in clock cycles (legal range 1..8).
REQ-002 The module SHALL have parameter DEPTH, default 4, giving result FIFO depth in entries (power of two, at least 2).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 issue_valid  input  1  an operation is presented to the FPU in this cycle.
REQ-006 issue_op  input  3  fpu_op of the issued operation.
REQ-007 out  input  32  FPU result word.
REQ-008 fpu_flags  input  8  FPU status, mapped as [0]=ine, [1]=overflow, [2]=underflow, [3]=div_by_zero, [4]=inf, [5]=zero, [6]=qnan, [7]=snan.
REQ-009 res_valid  output  1  FIFO head entry available.
REQ-010 res_ready  input  1  consumer accepts the head entry.
REQ-011 res_data  output  32  head entry result word.
REQ-012 res_op  output  3  head entry opcode.
REQ-013 res_flags  output  8  head entry flags.
REQ-014 sticky_flags  output  8  OR-accumulated flags of all captured results.
REQ-015 sticky_clr  input  1  clears sticky_flags and lost.
REQ-016 lost  output  1  sticky indicator that a result was dropped on FIFO overflow.
REQ-017 count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 The module SHALL carry {issue_valid, issue_op} through a LATENCY-stage tag shift register, so that a tag sampled at edge N emerges as a capture at edge N+LATENCY.
REQ-019 At the capture edge, the module SHALL sample out and fpu_flags together with the tag opcode; issue_valid=0 tags SHALL cause no capture, whatever out and fpu_flags hold.
REQ-020 A capture SHALL write {out, op, flags} at the write pointer when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-021 A capture with count==DEPTH and no same-cycle pop SHALL be dropped, set lost=1, and leave the FIFO contents and count unchanged.
REQ-022 A pop SHALL occur when res_valid & res_ready; popping an empty FIFO is impossible, since res_valid=0.
REQ-023 count SHALL update as +1 on push-only, -1 on pop-only, and unchanged on push+pop or idle.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 res_valid SHALL equal (count!=0), registered, so a captured entry is visible the cycle after its capture edge.
REQ-026 res_data, res_op and res_flags SHALL present the head entry (show-ahead) and SHALL be 0 when count==0.
REQ-027 On every tag-valid capture, including a dropped one, sticky_flags SHALL be ORed with fpu_flags.
REQ-028 sticky_clr SHALL zero sticky_flags and lost at the next edge; when it coincides with a capture, sticky_flags SHALL become exactly that capture's fpu_flags and lost SHALL reflect only that cycle's drop.
REQ-029 The module SHALL never stall issue; the upstream side is not back-pressured.

Reset
REQ-030 While rst=1, asynchronously, the module SHALL clear the tag pipeline, pointers, count, sticky_flags and lost, and drive res_valid=0, res_data=0, res_op=0, res_flags=0.
REQ-031 Tags in flight at reset assertion SHALL be discarded and SHALL produce no capture after rst deasserts.
REQ-032 FIFO storage SHALL NOT require reset.

Verification
REQ-033 Single op: issue_valid=1, issue_op=3'b011 at edge 1; out=32'h3F800000, flags=8'h00 at edge 5 -> res_valid=1 after edge 5, res_data=32'h3F800000, res_op=3, count=1; res_ready=1 -> res_valid=0 one edge later.
REQ-034 Overflow: 5 back-to-back issues, out=1..5, res_ready=0 -> count=4, lost=1, pops return 1, 2, 3, 4 in order.
REQ-035 Full with simultaneous pop: count=4, capture coincides with res_ready=1 -> count stays 4, lost stays 0, new entry becomes the tail.
REQ-036 Sticky: captures with flags 8'h03 then 8'h08 -> sticky_flags=8'h0B; sticky_clr coinciding with a capture of 8'h10 -> sticky_flags=8'h10.
REQ-037 Reset mid-flight: 2 tags in the pipeline, count=2, rst pulse between edges -> outputs zero immediately without a clock edge; no res_valid for 2*LATENCY cycles after release.
REQ-038 Idle noise: issue_valid=0 for 10 cycles while out and fpu_flags toggle -> count=0, sticky_flags=0.
